can_frame_demux: RTL and testbench

- Parametrised, clocked successor of the strobe-driven CAN-over-Ethernet word decoder. Sits after the Ethernet receive path in ethrnet_can.
- Watches a 16-bit word stream for configured CAN IDs, then collects the tagged data words that follow into per-ID, per-field registers.
- Commits a frame's fields atomically. Flags malformed and stalled frames.

---
 rtl/can_demux_pkg.sv | 17 +
 rtl/can_id_match.sv | 32 +++
 rtl/can_frame_demux.sv | 110 +++++++++++
 tb/tb_can_frame_demux.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/can_demux_pkg.sv
// can_demux_pkg: shared state encoding, default tables and slot addressing for can_frame_demux
package can_demux_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam int DEF_NUM_ID = 4;
  localparam int DEF_FIELDS = 3;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_DATA_W = 12;
  localparam logic [DEF_NUM_ID*DEF_WORD_W-1:0] DEF_ID_TABLE = {16'd520, 16'd515, 16'd514, 16'd513};
  localparam logic [DEF_NUM_ID*4-1:0] DEF_FCNT_TABLE = {4'd1, 4'd1, 4'd3, 4'd3};
  function automatic int slot_lsb(int k, int f, int fields = DEF_FIELDS, int data_w = DEF_DATA_W);
    return (k * fields + f - 1) * data_w;
  endfunction
  localparam logic [DEF_NUM_ID*DEF_FIELDS*DEF_DATA_W-1:0] DEF_RESET_TABLE =
    ((DEF_NUM_ID*DEF_FIELDS*DEF_DATA_W)'(175) << slot_lsb(2, 1)) |
    ((DEF_NUM_ID*DEF_FIELDS*DEF_DATA_W)'(100) << slot_lsb(0, 3));
endpackage

// File: rtl/can_id_match.sv
// can_id_match: combinational lookup of a word in the CAN ID table, lowest index wins
module can_id_match
  import can_demux_pkg::*;
#(
  parameter int NUM_ID = DEF_NUM_ID,
  parameter int WORD_W = DEF_WORD_W,
  parameter logic [NUM_ID*WORD_W-1:0] ID_TABLE = DEF_ID_TABLE
) (
  input  logic [WORD_W-1:0]         word_i,
  output logic                      hit,
  output logic [$clog2(NUM_ID)-1:0] idx
);
  localparam int IW = $clog2(NUM_ID);
  for (genvar a = 0; a < NUM_ID; a++) begin : g_a
    for (genvar b = a + 1; b < NUM_ID; b++) begin : g_b
      if (ID_TABLE[a*WORD_W +: WORD_W] == ID_TABLE[b*WORD_W +: WORD_W]) begin : g_dup
        $error("can_id_match: duplicate ID_TABLE entries");
      end
    end
  end
  // scan from the top so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_ID - 1; k >= 0; k--) begin
      if (word_i == ID_TABLE[k*WORD_W +: WORD_W]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/can_frame_demux.sv
// can_frame_demux: collects tagged CAN data words per ID and commits them atomically; CAN_DEMUX_TIMEOUT_EN adds a stall timeout
module can_frame_demux
  import can_demux_pkg::*;
#(
  parameter int NUM_ID = DEF_NUM_ID,
  parameter int FIELDS = DEF_FIELDS,
  parameter int WORD_W = DEF_WORD_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W = 2,
  parameter logic [NUM_ID*WORD_W-1:0] ID_TABLE = DEF_ID_TABLE,
  parameter logic [NUM_ID*4-1:0] FCNT_TABLE = DEF_FCNT_TABLE,
  parameter logic [NUM_ID*FIELDS*DATA_W-1:0] RESET_TABLE = DEF_RESET_TABLE,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             word_valid_i,
  input  logic [WORD_W-1:0]                word_i,
  output logic [NUM_ID*FIELDS*DATA_W-1:0]  data_o,
  output logic [NUM_ID-1:0]                frame_done_o,
  output logic                             err_o,
  output logic                             busy_o,
  output logic [$clog2(NUM_ID)-1:0]        active_id_o
);
  localparam int IW = $clog2(NUM_ID);
  if (FIELDS > 2**TAG_W - 1) begin : g_fields_chk
    $error("can_frame_demux: FIELDS does not fit the tag range");
  end
  for (genvar k = 0; k < NUM_ID; k++) begin : g_fcnt_chk
    if (FCNT_TABLE[k*4 +: 4] == 4'd0 || int'(FCNT_TABLE[k*4 +: 4]) > FIELDS) begin : g_bad
      $error("can_frame_demux: FCNT_TABLE entry out of range");
    end
  end
  if (TIMEOUT_CYC < 2) begin : g_to_chk
    $error("can_frame_demux: TIMEOUT_CYC too small");
  end
  logic [0:0] state;
  logic [TAG_W-1:0] exp_tag;
  logic [TAG_W-1:0] tag;
  logic [DATA_W-1:0] pay;
  logic [DATA_W-1:0] shadow [2**TAG_W];
  logic [3:0] fcnt;
  logic hit;
  logic [IW-1:0] idx;
  logic start, dat, good, bad, commit, tout;
  can_id_match #(.NUM_ID(NUM_ID), .WORD_W(WORD_W), .ID_TABLE(ID_TABLE)) u_match (
    .word_i(word_i),
    .hit(hit),
    .idx(idx)
  );
  assign tag = word_i[DATA_W +: TAG_W];
  assign pay = word_i[DATA_W-1:0];
  assign fcnt = FCNT_TABLE[active_id_o*4 +: 4];
  assign start = word_valid_i && hit;
  assign dat = word_valid_i && !hit && tag != '0 && state == COLLECT;
  assign good = dat && tag == exp_tag;
  assign bad = dat && tag != exp_tag;
  assign commit = good && int'(exp_tag) == int'(fcnt);
  assign busy_o = state == COLLECT;
`ifdef CAN_DEMUX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmr;
  // counts cycles inside a frame that did not accept an ID or data word
  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || start || dat) tmr <= '0;
    else tmr <= tmr + 1'b1;
  end
  assign tout = state == COLLECT && !start && !dat && tmr == TW'(TIMEOUT_CYC - 1);
`else
  assign tout = 1'b0;
`endif
  // frame FSM: an ID word always restarts collection, data words advance or drop the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      active_id_o <= '0;
      exp_tag <= '0;
      shadow <= '{default: '0};
      frame_done_o <= '0;
      err_o <= 1'b0;
    end else begin
      frame_done_o <= '0;
      err_o <= 1'b0;
      if (start) begin
        state <= COLLECT;
        active_id_o <= idx;
        exp_tag <= TAG_W'(1);
      end else if (good) begin
        shadow[exp_tag] <= pay;
        if (commit) begin
          state <= IDLE;
          frame_done_o[active_id_o] <= 1'b1;
        end else exp_tag <= exp_tag + 1'b1;
      end else if (bad || tout) begin
        state <= IDLE;
        err_o <= 1'b1;
      end
    end
  end
  // the last field bypasses the shadow so every field of the frame lands on the same edge
  always_ff @(posedge clk) begin
    if (rst) data_o <= RESET_TABLE;
    else if (commit) begin
      for (int k = 0; k < NUM_ID; k++)
        for (int f = 1; f <= FIELDS; f++)
          if (int'(active_id_o) == k && f <= int'(fcnt))
            data_o[slot_lsb(k, f, FIELDS, DATA_W) +: DATA_W] <= f == int'(exp_tag) ? pay : shadow[f[TAG_W-1:0]];
    end
  end
endmodule

// File: tb/tb_can_frame_demux.sv
// tb_can_frame_demux: scoreboard bench with a frame-level reference model for can_frame_demux
module tb_can_frame_demux;
`ifdef CAN_DEMUX_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic word_valid_i = 1'b0;
  logic [15:0] word_i = '0;
  logic [143:0] data_o;
  logic [3:0] frame_done_o;
  logic err_o, busy_o;
  logic [1:0] active_id_o;
  can_frame_demux #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .word_valid_i(word_valid_i),
    .word_i(word_i),
    .data_o(data_o),
    .frame_done_o(frame_done_o),
    .err_o(err_o),
    .busy_o(busy_o),
    .active_id_o(active_id_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic busy;
    logic [1:0] aid;
    logic [3:0] done;
    logic err;
    logic [143:0] data;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ids[4] = '{513, 514, 515, 520};
  int fcnt[4] = '{3, 3, 1, 1};
  logic [11:0] mem [4][3];
  int active = -1;
  int last = 0;
  int idle = 0;
  int got[$];
  logic [143:0] shown;
  function automatic logic [143:0] pack_mem();
    logic [143:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      for (int f = 0; f < 3; f++)
        r[(k*3+f)*12 +: 12] = mem[k][f];
    return r;
  endfunction
  task automatic chk(input string n, input logic [143:0] a, input logic [143:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++)
      for (int f = 0; f < 3; f++)
        mem[k][f] = '0;
    mem[2][0] = 12'd175;
    mem[0][2] = 12'd100;
    active = -1;
    last = 0;
    idle = 0;
    got.delete();
    shown = pack_mem();
  endtask
  // frame-level model: what the outputs must show after the edge that samples this word
  task automatic step(input logic v, input logic [15:0] w);
    exp_t e;
    int k;
    logic [1:0] t;
    e.done = '0;
    e.err = 1'b0;
    k = -1;
    for (int i = 3; i >= 0; i--) if (int'(w) == ids[i]) k = i;
    t = w[13:12];
    if (v && k >= 0) begin
      active = k;
      last = k;
      got.delete();
      idle = 0;
    end else if (active >= 0) begin
      if (v && t != 2'd0) begin
        idle = 0;
        if (int'(t) == got.size() + 1) begin
          got.push_back(int'(w[11:0]));
          if (got.size() == fcnt[active]) begin
            for (int f = 0; f < got.size(); f++) mem[active][f] = 12'(got[f]);
            e.done[active] = 1'b1;
            active = -1;
          end
        end else begin
          e.err = 1'b1;
          active = -1;
        end
      end else begin
`ifdef CAN_DEMUX_TIMEOUT_EN
        if (idle == TO - 1) begin
          e.err = 1'b1;
          active = -1;
        end else idle++;
`endif
      end
    end
    e.busy = active >= 0;
    e.aid = 2'(last);
    e.data = pack_mem();
    q.push_back(e);
  endtask
  task automatic cycle(input logic v, input logic [15:0] w);
    word_valid_i = v;
    word_i = w;
    step(v, w);
    @(posedge clk);
    #1;
  endtask
  task automatic idle_n(input int n);
    repeat (n) cycle(1'b0, 16'($urandom));
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    word_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    chk("reset data", data_o, shown);
    chk("reset done", frame_done_o, 0);
    chk("reset err", err_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset active_id", active_id_o, 0);
    #1;
  endtask
  // monitor: every post-reset cycle pops one expectation and compares all outputs
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("frame_done", frame_done_o, e.done);
        chk("err", err_o, e.err);
        chk("busy", busy_o, e.busy);
        chk("active_id", active_id_o, e.aid);
        chk("data", data_o, e.data);
        shown = e.data;
      end else begin
        chk("idle pulses", {frame_done_o, err_o}, 0);
        chk("idle data", data_o, shown);
      end
    end
  end
  initial begin
    model_reset();
    do_reset();
    cycle(1, 16'd513); cycle(1, 16'h1ABC); cycle(1, 16'h2123); cycle(1, 16'h3456);
    idle_n(2);
    cycle(1, 16'd515); cycle(1, 16'h1055); idle_n(1);
    cycle(1, 16'd515); cycle(1, 16'h2077); idle_n(2);
    cycle(1, 16'd514); cycle(1, 16'h1011); cycle(1, 16'd513);
    cycle(1, 16'h1001); cycle(1, 16'h2002); cycle(1, 16'h3003); idle_n(2);
    cycle(1, 16'd514); cycle(1, 16'h1011); cycle(0, 16'h0000); cycle(1, 16'h0FFF);
    cycle(0, 16'h1234); cycle(1, 16'h2022); cycle(0, 16'h0000); cycle(1, 16'h3033); idle_n(2);
    cycle(1, 16'd515); cycle(1, 16'hD0AA); idle_n(2);
    cycle(1, 16'd520); cycle(1, 16'h1FFF); cycle(1, 16'd520); cycle(1, 16'h3001); idle_n(2);
`ifdef CAN_DEMUX_TIMEOUT_EN
    cycle(1, 16'd513); cycle(1, 16'h1001); idle_n(10);
    cycle(1, 16'd513); cycle(1, 16'h1001); idle_n(6); cycle(1, 16'h2005); idle_n(3);
`endif
    cycle(1, 16'd513); cycle(1, 16'h1001);
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [15:0] w;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) cycle(1'b0, 16'($urandom));
      if (r < 2) w = 16'(ids[$urandom_range(0, 3)]);
      else if (r == 2) w = 16'($urandom);
      else if (r == 3) w = {2'($urandom), 2'b00, 12'($urandom)};
      else if (r == 9) w = {2'($urandom), 2'($urandom_range(1, 3)), 12'($urandom)};
      else w = {2'($urandom), 2'(got.size() + 1), 12'($urandom)};
      cycle(1'b1, w);
    end
    idle_n(3);
    @(negedge clk);
    #1;
    chk("scoreboard drained", 144'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
